// File: rtl/atm_pkg.sv
// Shared constants and types for the ATM card/PIN authentication front end.
package atm_pkg;

    typedef logic [7:0] card_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        CHECK   = 2'd2,
        GRANTED = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_lock_table.sv
// Small table of locked card numbers: first-free write, round-robin eviction when full.
module atm_lock_table
    import atm_pkg::*;
#(
    parameter int LOCK_SLOTS = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  card_t lookup_card,
    output logic  hit,
    input  logic  wr_en,
    input  card_t wr_card
);

    localparam int PTRW = (LOCK_SLOTS > 1) ? $clog2(LOCK_SLOTS) : 1;

    card_t                 entry_q [LOCK_SLOTS];
    logic [LOCK_SLOTS-1:0] valid_q;
    logic [PTRW-1:0]       ptr_q;

    logic            wr_present;
    logic            free_found;
    logic [PTRW-1:0] free_idx;
    logic [PTRW-1:0] wr_slot;
    logic            do_wr;

    always_comb begin
        hit        = 1'b0;
        wr_present = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < LOCK_SLOTS; i++) begin
            if (valid_q[i] && entry_q[i] == lookup_card) hit = 1'b1;
            if (valid_q[i] && entry_q[i] == wr_card)     wr_present = 1'b1;
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = PTRW'(i);
            end
        end
    end

    assign wr_slot = free_found ? free_idx : ptr_q;
    assign do_wr   = wr_en && !wr_present;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (do_wr) begin
            valid_q[wr_slot] <= 1'b1;
            // The eviction pointer only moves when a full table is overwritten.
            if (!free_found) begin
                ptr_q <= (ptr_q == PTRW'(LOCK_SLOTS - 1)) ? '0 : ptr_q + PTRW'(1);
            end
        end
    end

    // NOTE: entry contents need no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (do_wr) entry_q[wr_slot] <= wr_card;
    end

endmodule

// File: rtl/atm_pin_auth.sv
// Card insertion and PIN entry front end; hands authenticated sessions to the transaction FSM.
module atm_pin_auth
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = 4,
    parameter int MAX_TRIES  = 3,
    parameter int TIMEOUT    = 1000,
    parameter int LOCK_SLOTS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            card_valid,
    input  logic [7:0]                      card_no,
    input  logic                            key_valid,
    input  logic [3:0]                      key_code,
    input  logic [4*PIN_DIGITS-1:0]         ref_pin,
    input  logic                            session_end,
    output logic                            session_valid,
    output logic [7:0]                      session_card,
    output logic                            auth_ok,
    output logic                            auth_fail,
    output logic                            locked,
    output logic                            timeout,
    output logic [$clog2(PIN_DIGITS+1)-1:0] digit_count
);

    localparam int PW  = 4 * PIN_DIGITS;
    localparam int CW  = $clog2(PIN_DIGITS + 1);
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int TMW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    card_t          card_q, card_d;
    logic [PW-1:0]  buf_q, buf_d;
    logic [CW-1:0]  count_q, count_d;
    logic [TRW-1:0] tries_q, tries_d;
    logic [TMW-1:0] timer_q, timer_d;
    logic           auth_ok_q, auth_ok_d;
    logic           auth_fail_q, auth_fail_d;
    logic           locked_q, locked_d;
    logic           timeout_q, timeout_d;

    logic card_in, lock_hit, lock_wr;
    logic buf_full, pin_match, last_try, timer_hit;

    assign card_in   = card_valid && (card_no != 8'd0);
    assign buf_full  = (count_q == CW'(PIN_DIGITS));
    assign pin_match = (buf_q == ref_pin);
    assign last_try  = (tries_q == TRW'(MAX_TRIES - 1));
    assign timer_hit = (timer_q == TMW'(TIMEOUT - 1));

    atm_lock_table #(
        .LOCK_SLOTS (LOCK_SLOTS)
    ) u_lock_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_card (card_no),
        .hit         (lock_hit),
        .wr_en       (lock_wr),
        .wr_card     (card_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card_q      <= '0;
            buf_q       <= '0;
            count_q     <= '0;
            tries_q     <= '0;
            timer_q     <= '0;
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            card_q      <= card_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            tries_q     <= tries_d;
            timer_q     <= timer_d;
            auth_ok_q   <= auth_ok_d;
            auth_fail_q <= auth_fail_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (card_in && !lock_hit) state_d = ENTRY;
            end
            ENTRY: begin
                if (key_valid) begin
                    if (key_code == KEY_CANCEL)                 state_d = IDLE;
                    else if (key_code == KEY_ENTER && buf_full) state_d = CHECK;
                end else if (timer_hit) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (pin_match)     state_d = GRANTED;
                else if (last_try) state_d = IDLE;
                else               state_d = ENTRY;
            end
            GRANTED: begin
                if (session_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values and registered result pulses.
    always_comb begin
        card_d      = card_q;
        buf_d       = buf_q;
        count_d     = count_q;
        tries_d     = tries_q;
        timer_d     = timer_q;
        auth_ok_d   = 1'b0;
        auth_fail_d = 1'b0;
        locked_d    = 1'b0;
        timeout_d   = 1'b0;
        lock_wr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (card_in) begin
                    if (lock_hit) begin
                        locked_d = 1'b1;
                    end else begin
                        card_d  = card_no;
                        buf_d   = '0;
                        count_d = '0;
                        tries_d = '0;
                        timer_d = '0;
                    end
                end
            end
            ENTRY: begin
                if (key_valid) begin
                    timer_d = '0;
                    if (is_digit(key_code)) begin
                        if (!buf_full) begin
                            buf_d   = (buf_q << 4) | PW'(key_code);
                            count_d = count_q + CW'(1);
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d   = '0;
                        count_d = '0;
                    end else if (key_code == KEY_CANCEL) begin
                        card_d  = '0;
                        buf_d   = '0;
                        count_d = '0;
                        tries_d = '0;
                    end
                end else if (timer_hit) begin
                    timeout_d = 1'b1;
                    card_d    = '0;
                    buf_d     = '0;
                    count_d   = '0;
                    tries_d   = '0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
            CHECK: begin
                if (pin_match) begin
                    auth_ok_d = 1'b1;
                end else if (last_try) begin
                    lock_wr  = 1'b1;
                    locked_d = 1'b1;
                    card_d   = '0;
                    buf_d    = '0;
                    count_d  = '0;
                    tries_d  = '0;
                    timer_d  = '0;
                end else begin
                    auth_fail_d = 1'b1;
                    tries_d     = tries_q + TRW'(1);
                    buf_d       = '0;
                    count_d     = '0;
                    timer_d     = '0;
                end
            end
            GRANTED: begin
                if (session_end) begin
                    card_d  = '0;
                    buf_d   = '0;
                    count_d = '0;
                    tries_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        session_valid = (state_q == GRANTED);
        session_card  = (state_q == IDLE) ? 8'd0 : card_q;
    end

    assign auth_ok     = auth_ok_q;
    assign auth_fail   = auth_fail_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;
    assign digit_count = count_q;

endmodule

// File: tb/tb_atm_pin_auth.sv
// Directed bench for atm_pin_auth with TIMEOUT=16 and a 4-slot lock table.
module tb_atm_pin_auth;
    import atm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        card_valid;
    logic [7:0]  card_no;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] ref_pin;
    logic        session_end;
    logic        session_valid;
    logic [7:0]  session_card;
    logic        auth_ok;
    logic        auth_fail;
    logic        locked;
    logic        timeout;
    logic [2:0]  digit_count;

    int n_vec = 0;
    int n_err = 0;
    int cnt_ok = 0, cnt_fail = 0, cnt_lock = 0, cnt_to = 0;
    int save_ok, save_fail, save_lock, save_to;

    atm_pin_auth #(
        .PIN_DIGITS (4),
        .MAX_TRIES  (3),
        .TIMEOUT    (16),
        .LOCK_SLOTS (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .card_valid    (card_valid),
        .card_no       (card_no),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .ref_pin       (ref_pin),
        .session_end   (session_end),
        .session_valid (session_valid),
        .session_card  (session_card),
        .auth_ok       (auth_ok),
        .auth_fail     (auth_fail),
        .locked        (locked),
        .timeout       (timeout),
        .digit_count   (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (auth_ok)   cnt_ok++;
        if (auth_fail) cnt_fail++;
        if (locked)    cnt_lock++;
        if (timeout)   cnt_to++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [7:0] c);
        card_valid = 1'b1;
        card_no    = c;
        step();
        card_valid = 1'b0;
        card_no    = 8'd0;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic enter_pin(input logic [15:0] pin);
        key(pin[15:12]);
        key(pin[11:8]);
        key(pin[7:4]);
        key(pin[3:0]);
        key(KEY_ENTER);
    endtask

    task automatic end_session();
        session_end = 1'b1;
        step();
        session_end = 1'b0;
    endtask

    task automatic lock_card(input logic [7:0] c);
        insert(c);
        repeat (3) begin
            enter_pin(16'h9999);
            step();
        end
        check("lock_card_pulse", locked, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        card_valid  = 1'b0;
        card_no     = 8'd0;
        key_valid   = 1'b0;
        key_code    = 4'd0;
        ref_pin     = 16'h1234;
        session_end = 1'b0;

        // Reset state
        #3;
        check("rst_session_valid", session_valid, 1'b0);
        check("rst_session_card", session_card, 8'h00);
        check("rst_digit_count", digit_count, 3'd0);
        check("rst_pulses", {auth_ok, auth_fail, locked, timeout}, 4'b0000);
        #9 rst_n = 1'b1;
        step();

        // 1: correct PIN, session held until session_end
        insert(8'h21);
        check("t1_card_latched", session_card, 8'h21);
        check("t1_not_granted", session_valid, 1'b0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        check("t1_digits", digit_count, 3'd4);
        key(KEY_ENTER);
        check("t1_check_no_pulse", auth_ok, 1'b0);
        step();
        check("t1_auth_ok", auth_ok, 1'b1);
        check("t1_session_valid", session_valid, 1'b1);
        step();
        check("t1_auth_ok_width", auth_ok, 1'b0);
        insert(8'h55);
        check("t1_second_card_ignored", session_card, 8'h21);
        check("t1_still_granted", session_valid, 1'b1);
        end_session();
        check("t1_end_valid", session_valid, 1'b0);
        check("t1_end_card", session_card, 8'h00);

        // 2: short ENTER ignored, then completed PIN accepted
        insert(8'h21);
        save_ok = cnt_ok; save_fail = cnt_fail;
        key(4'h1); key(4'h2); key(KEY_ENTER);
        step();
        check("t2_short_ok", cnt_ok, save_ok);
        check("t2_short_fail", cnt_fail, save_fail);
        check("t2_short_digits", digit_count, 3'd2);
        key(4'h3); key(4'h4);
        key(4'h7);
        check("t2_fifth_digit_ignored", digit_count, 3'd4);
        key(KEY_ENTER);
        step();
        check("t2_auth_ok", auth_ok, 1'b1);
        end_session();

        // 3: three wrong PINs lock the card
        insert(8'h21);
        key(4'h9); key(KEY_CLEAR);
        check("t3_clear", digit_count, 3'd0);
        enter_pin(16'h9999);
        step();
        check("t3_fail1", auth_fail, 1'b1);
        check("t3_fail1_digits", digit_count, 3'd0);
        check("t3_fail1_card", session_card, 8'h21);
        enter_pin(16'h9999);
        step();
        check("t3_fail2", auth_fail, 1'b1);
        enter_pin(16'h9999);
        step();
        check("t3_locked", locked, 1'b1);
        check("t3_locked_nofail", auth_fail, 1'b0);
        check("t3_locked_card", session_card, 8'h00);
        step();
        check("t3_locked_width", locked, 1'b0);
        insert(8'h21);
        check("t3_relock", locked, 1'b1);
        check("t3_relock_idle", session_card, 8'h00);
        key(4'h5);
        check("t3_idle_key_ignored", digit_count, 3'd0);

        // 4: inactivity timeout, and key restart; card wins over key in IDLE
        card_valid = 1'b1; card_no = 8'h30;
        key_valid  = 1'b1; key_code = 4'h1;
        step();
        card_valid = 1'b0; card_no = 8'd0;
        key_valid  = 1'b0; key_code = 4'd0;
        check("t4_card_wins", session_card, 8'h30);
        check("t4_key_dropped", digit_count, 3'd0);
        save_to = cnt_to;
        repeat (15) step();
        check("t4_no_early_timeout", cnt_to, save_to);
        check("t4_still_entry", session_card, 8'h30);
        step();
        check("t4_timeout", timeout, 1'b1);
        check("t4_timeout_card", session_card, 8'h00);
        step();
        check("t4_timeout_width", timeout, 1'b0);
        insert(8'h30);
        repeat (9) step();
        key(4'hD);
        save_to = cnt_to;
        repeat (15) step();
        check("t4_restart_no_timeout", cnt_to, save_to);
        check("t4_restart_entry", session_card, 8'h30);
        step();
        check("t4_restart_timeout", timeout, 1'b1);

        // 6: reset mid-entry, then cancel
        insert(8'h44);
        key(4'h1); key(4'h2);
        check("t6_digits_before", digit_count, 3'd2);
        save_ok = cnt_ok; save_fail = cnt_fail; save_lock = cnt_lock; save_to = cnt_to;
        rst_n = 1'b0;
        #1;
        check("t6_rst_digits", digit_count, 3'd0);
        check("t6_rst_card", session_card, 8'h00);
        step();
        #2 rst_n = 1'b1;
        repeat (2) step();
        check("t6_rst_no_pulse", cnt_ok + cnt_fail + cnt_lock + cnt_to,
              save_ok + save_fail + save_lock + save_to);
        insert(8'h21);
        check("t6_table_cleared", session_card, 8'h21);
        check("t6_not_locked", locked, 1'b0);
        key(KEY_CANCEL);
        check("t6_cancel_card", session_card, 8'h00);
        check("t6_cancel_digits", digit_count, 3'd0);

        // 5: five locks into four slots evict the first card
        lock_card(8'h61);
        lock_card(8'h62);
        lock_card(8'h63);
        lock_card(8'h64);
        lock_card(8'h65);
        insert(8'h61);
        check("t5_evicted_enters", session_card, 8'h61);
        check("t5_evicted_no_lock", locked, 1'b0);
        enter_pin(16'h1234);
        step();
        check("t5_evicted_auth_ok", auth_ok, 1'b1);
        end_session();
        for (int c = 8'h62; c <= 8'h65; c++) begin
            insert(8'(c));
            check($sformatf("t5_locked_%0h", c), locked, 1'b1);
            check($sformatf("t5_idle_%0h", c), session_card, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
